// File: rtl/iob_axistream_out_pack.sv
// CPU-written word FIFO feeding an AXI-Stream serializer that emits each word LSB-first.
// Optional packet counter at address 7 is built only when IOB_AXISTREAM_OUT_PKT_CNT_EN is defined.
module iob_axistream_out_pack #(
    parameter int TDATA_W         = 8,
    parameter int DATA_W          = 32,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int ADDR_W          = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic [TDATA_W-1:0]  tdata,
    output logic                tvalid,
    input  logic                tready,
    output logic                tlast
);
    localparam int R     = DATA_W / TDATA_W;
    localparam int CNT_W = $clog2(R + 1);
    localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int ENT_W = DATA_W + 1 + CNT_W;
    localparam logic [CNT_W-1:0]  R_CNT     = CNT_W'(R);
    localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [ADDR_W-1:0] A_IN      = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_LAST    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_LASTB   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_LEVEL   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_ENABLE  = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_SOFTRST = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_PKTCNT  = ADDR_W'(7);

    logic                       ready_reg, enable_reg, overflow_reg;
    logic [DATA_W-1:0]          rdata_reg, rdata_next, pkt_rdata;
    logic [CNT_W-1:0]           lastbeats_reg, lastbeats_next;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]           level_reg;
    logic [ENT_W-1:0]           mem [DEPTH];
    logic [ENT_W-1:0]           head;
    logic                       wr, rd, push_req, push, soft_rst, full, empty;
    logic [DATA_W-1:0]          shift_reg, shift_next, shift_after;
    logic [CNT_W-1:0]           rem_reg, rem_next, rem_after;
    logic                       flag_reg, flag_next, tvalid_reg, tvalid_next, tlast_reg, tlast_next;
    logic                       beat_done, load;

    assign wr       = valid && (wstrb != '0);
    assign rd       = valid && (wstrb == '0);
    assign push_req = wr && (address == A_IN || address == A_LAST);
    assign soft_rst = wr && (address == A_SOFTRST);
    assign full     = (level_reg == DEPTH_LVL);
    assign empty    = (level_reg == '0);
    // A full FIFO still accepts a push when the serializer pops in the same cycle.
    assign push     = push_req && (!full || load);
    assign head     = mem[rd_ptr_reg];

    assign lastbeats_next = (wdata == '0 || wdata > DATA_W'(R)) ? R_CNT : wdata[CNT_W-1:0];

    assign ready  = ready_reg;
    assign rdata  = rdata_reg;
    assign tdata  = shift_reg[TDATA_W-1:0];
    assign tvalid = tvalid_reg;
    assign tlast  = tlast_reg;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {(address == A_LAST) ? lastbeats_reg : R_CNT, address == A_LAST, wdata};
    end

    // rem counts beats of the loaded word not yet accepted; a loaded word waits while disabled.
    always_comb begin
        beat_done   = tvalid_reg && tready;
        rem_after   = beat_done ? rem_reg - CNT_W'(1) : rem_reg;
        shift_after = beat_done ? shift_reg >> TDATA_W : shift_reg;
        load        = (rem_after == '0) && enable_reg && !empty;
        if (load) begin
            shift_next  = head[DATA_W-1:0];
            rem_next    = head[ENT_W-1 -: CNT_W];
            flag_next   = head[DATA_W];
            tvalid_next = 1'b1;
        end else begin
            shift_next  = shift_after;
            rem_next    = rem_after;
            flag_next   = flag_reg;
            tvalid_next = (rem_after != '0) && ((tvalid_reg && !beat_done) || enable_reg);
        end
        tlast_next = flag_next && (rem_next == CNT_W'(1));
    end

    always_comb begin
        rdata_next = '0;
        if (rd) begin
            case (address)
                A_LASTB:  rdata_next = DATA_W'(lastbeats_reg);
                A_STATUS: rdata_next = DATA_W'({overflow_reg, empty, full});
                A_LEVEL:  rdata_next = DATA_W'(level_reg);
                A_ENABLE: rdata_next = DATA_W'(enable_reg);
                A_PKTCNT: rdata_next = pkt_rdata;
                default:  rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg     <= 1'b0;
            rdata_reg     <= '0;
            enable_reg    <= 1'b0;
            lastbeats_reg <= R_CNT;
            overflow_reg  <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            shift_reg     <= '0;
            rem_reg       <= '0;
            flag_reg      <= 1'b0;
            tvalid_reg    <= 1'b0;
            tlast_reg     <= 1'b0;
        end else begin
            ready_reg <= valid;
            rdata_reg <= rdata_next;
            if (wr && address == A_LASTB)
                lastbeats_reg <= lastbeats_next;
            if (wr && address == A_ENABLE)
                enable_reg <= wdata[0];
            if (soft_rst) begin
                overflow_reg <= 1'b0;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                level_reg    <= '0;
                shift_reg    <= '0;
                rem_reg      <= '0;
                flag_reg     <= 1'b0;
                tvalid_reg   <= 1'b0;
                tlast_reg    <= 1'b0;
            end else begin
                if (push_req && !push)
                    overflow_reg <= 1'b1;
                else if (rd && address == A_STATUS)
                    overflow_reg <= 1'b0;
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (load)
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                level_reg  <= level_reg + LVL_W'(push) - LVL_W'(load);
                shift_reg  <= shift_next;
                rem_reg    <= rem_next;
                flag_reg   <= flag_next;
                tvalid_reg <= tvalid_next;
                tlast_reg  <= tlast_next;
            end
        end
    end

`ifdef IOB_AXISTREAM_OUT_PKT_CNT_EN
    logic [15:0] pkt_cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pkt_cnt_reg <= '0;
        else if (beat_done && tlast_reg)
            pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
    end
    assign pkt_rdata = DATA_W'(pkt_cnt_reg);
`else
    assign pkt_rdata = '0;
`endif

endmodule

// File: doc/iob_axistream_out_pack.md
IOB_AXISTREAM_OUT_PACK -- requirements
Module: iob_axistream_out_pack

Interface
REQ-001 SHALL have parameter TDATA_W, default 8, stream beat width; legal values 8, 16 or 32, and it SHALL divide DATA_W.
REQ-002 SHALL have parameter DATA_W, default 32, CPU data width.
REQ-003 SHALL have parameter FIFO_DEPTH_LOG2, default 4, log2 of FIFO depth in DATA_W words.
REQ-004 SHALL have parameter ADDR_W, default 3, CPU word-address width.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have CPU native slave ports: valid (in, 1), address (in, ADDR_W), wdata (in, DATA_W), wstrb (in, DATA_W/8), rdata (out, DATA_W), ready (out, 1).
REQ-008 SHALL have stream ports: tdata (out, TDATA_W), tvalid (out, 1), tready (in, 1), tlast (out, 1).

Function
REQ-009 ready SHALL assert exactly one cycle after any valid; rdata SHALL be registered and valid in that same cycle; wstrb==0 means read.
REQ-010 Register map (word address): 0 IN (W, push word), 1 LAST (W, push word marked end-of-packet), 2 LASTBEATS (R/W, 1..R where R=DATA_W/TDATA_W), 3 STATUS (R: bit0 full, bit1 empty, bit2 overflow), 4 LEVEL (R, words in FIFO, FIFO_DEPTH_LOG2+1 bits), 5 ENABLE (R/W, bit0), 6 SOFTRST (W, pulse), 7 PKTCNT (R).
REQ-011 Each FIFO entry SHALL hold DATA_W data, 1 last flag and a beat count (R for IN writes; the LASTBEATS value latched at push for LAST writes).
REQ-012 A write to IN/LAST while full SHALL be dropped and SHALL set the sticky overflow bit; a STATUS read SHALL clear overflow after returning it.
REQ-013 The serializer SHALL emit beats LSB-first: beat k = word[(k+1)*TDATA_W-1 : k*TDATA_W], for k = 0 .. count-1.
REQ-014 tlast SHALL be 1 only on the final beat of an entry whose last flag is set.
REQ-015 tdata, tlast and tvalid SHALL come from registers; while tvalid=1 and tready=0 they SHALL hold stable.
REQ-016 A beat completes on a cycle with tvalid=1 and tready=1; the next beat, if available, SHALL be presented in the following cycle (zero-bubble throughput of one beat per cycle).
REQ-017 Latency: a word pushed at cycle N into an empty, idle, enabled block SHALL give tvalid=1 at cycle N+2.
REQ-018 A push and a pop in the same cycle SHALL both succeed and leave LEVEL unchanged, including when the FIFO is full.
REQ-019 Read and write pointers SHALL wrap modulo 2^FIFO_DEPTH_LOG2; full/empty SHALL be derived from a FIFO_DEPTH_LOG2+1-bit level.
REQ-020 ENABLE=0 SHALL stop loading new entries; a beat already presented SHALL stay valid until accepted (no tvalid retraction), and the remaining beats of a loaded word SHALL be held.
REQ-021 A LASTBEATS write of 0 or of a value greater than R SHALL be stored as R.
REQ-022 A SOFTRST write SHALL, in the next cycle, empty the FIFO, discard the serializer word, deassert tvalid and clear overflow; this is the only permitted tvalid retraction. Registers LASTBEATS, ENABLE and PKTCNT SHALL be kept.

Reset
REQ-023 rst_n=0 SHALL asynchronously force: tvalid=0, tdata=0, tlast=0, ready=0, rdata=0, FIFO empty, level 0, overflow=0, ENABLE=0, LASTBEATS=R, PKTCNT=0.
REQ-024 Reset release SHALL be synchronous to clk; the first CPU access SHALL be accepted on the first cycle after release.

Configuration
REQ-025 Macro IOB_AXISTREAM_OUT_PKT_CNT_EN defined: PKTCNT SHALL be a 16-bit counter that increments on every beat handshake with tlast=1 and wraps from 0xFFFF to 0.
REQ-026 Macro IOB_AXISTREAM_OUT_PKT_CNT_EN undefined: no counter logic SHALL exist and address 7 SHALL read 0.

Verification
REQ-027 TDATA_W=8, ENABLE=1, tready=1; push IN 0x44332211 -> beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles, tlast=0, first tvalid at N+2.
REQ-028 LASTBEATS=2; push LAST 0xDDCCBBAA -> beats 0xAA, 0xBB only, tlast=1 on 0xBB; PKTCNT reads 1 with the macro and 0 without it.
REQ-029 tready=0, push 2^FIFO_DEPTH_LOG2+1 words -> STATUS full=1, LEVEL=16 (depth 16), overflow=1; a second STATUS read shows overflow=0.
REQ-030 Hold tready low 5 cycles mid-word with tvalid=1 -> tdata and tlast unchanged across those cycles; toggling tready afterwards loses and duplicates no beats.
REQ-031 Assert SOFTRST mid-packet -> next cycle tvalid=0, LEVEL=0, ENABLE unchanged; a new push then streams correctly.
REQ-032 Pulse rst_n low mid-stream, asynchronous to clk -> tvalid drops immediately, all outputs and state return to REQ-023 values.
